// File: rtl/register_file.sv
`default_nettype none
// ============================================================================
// Module      : register_file
// Description : 16 x 32-bit ARM-style register file. Two combinational read
//               ports and one write port updated on the falling clock edge.
//               Address 15 is not stored; reads of it return the supplied
//               R15 (PC+8) value and writes to it are dropped.
// Revision    : 1.0 - initial release
// ============================================================================
module register_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int PC_IDX = 15
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [ADDR_W-1:0] A1,
    input  logic [ADDR_W-1:0] A2,
    input  logic [ADDR_W-1:0] A3,
    input  logic [DATA_W-1:0] WD3,
    input  logic              WE3,
    input  logic [DATA_W-1:0] R15,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2
);

    localparam int              c_num_regs = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] c_pc_addr = ADDR_W'(PC_IDX);

    // The PC slot exists in the array only to keep indexing uniform. It is
    // cleared by reset, never written and never read, so it trims away.
    logic [DATA_W-1:0] r_regs [0:c_num_regs-1];

    logic w_wr_en;
    logic [DATA_W-1:0] w_rd1;
    logic [DATA_W-1:0] w_rd2;

    // PC writes are handled by the fetch logic, so a write aimed at R15 is dropped.
    assign w_wr_en = WE3 && (A3 != c_pc_addr);

    // Falling-edge update: a write made this cycle is readable before the
    // rising-edge consumers sample. Reset wins over a concurrent write.
    always_ff @(negedge CLK) begin
        if (RST) begin
            for (int i = 0; i < c_num_regs; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[A3] <= WD3;
        end
    end

    // Zero-latency reads with no write bypass; R15 is muxed in combinationally.
    always_comb begin
        w_rd1 = (A1 == c_pc_addr) ? R15 : r_regs[A1];
        w_rd2 = (A2 == c_pc_addr) ? R15 : r_regs[A2];
    end

    assign RD1 = w_rd1;
    assign RD2 = w_rd2;

endmodule
`default_nettype wire

// File: tb/tb_register_file.sv
`default_nettype none
// ============================================================================
// Module      : tb_register_file
// Description : Directed self-checking bench for register_file. Expected
//               register contents are tracked in a small reference array
//               that the bench updates from the stimulus it applies.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_register_file;

    logic        CLK;
    logic        RST;
    logic [3:0]  A1;
    logic [3:0]  A2;
    logic [3:0]  A3;
    logic [31:0] WD3;
    logic        WE3;
    logic [31:0] R15;
    logic [31:0] RD1;
    logic [31:0] RD2;

    int errors;
    int checks;
    logic [31:0] exp_regs [0:14];

    register_file #(
        .DATA_W(32),
        .ADDR_W(4),
        .PC_IDX(15)
    ) u_dut (
        .CLK (CLK),
        .RST (RST),
        .A1  (A1),
        .A2  (A2),
        .A3  (A3),
        .WD3 (WD3),
        .WE3 (WE3),
        .R15 (R15),
        .RD1 (RD1),
        .RD2 (RD2)
    );

    // Free-running clock, period 10; the DUT acts on the falling edge.
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance past the next falling edge; inputs change 1 time unit later.
    task automatic step();
        @(negedge CLK);
        #1;
    endtask

    // Read every stored register through both ports (A1=i, A2=14-i).
    task automatic sweep_read(input string tag);
        for (int i = 0; i < 15; i++) begin
            A1 = 4'(i);
            A2 = 4'(14 - i);
            #1;
            check($sformatf("%s_rd1_r%0d", tag, i), RD1, exp_regs[i]);
            check($sformatf("%s_rd2_r%0d", tag, 14 - i), RD2, exp_regs[14 - i]);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        RST = 1'b1;
        WE3 = 1'b0;
        A1 = '0;
        A2 = '0;
        A3 = '0;
        WD3 = '0;
        R15 = '0;
        for (int i = 0; i < 15; i++) exp_regs[i] = 32'h0;

        // Reset for one falling edge, then everything reads zero.
        step();
        RST = 1'b0;
        sweep_read("reset");

        // Write R2 = 15, read R1 and R2.
        WE3 = 1'b1; A3 = 4'd2; WD3 = 32'd15;
        step();
        exp_regs[2] = 32'd15;
        WE3 = 1'b0;
        A1 = 4'd1; A2 = 4'd2;
        #1;
        check("wr_r1_untouched", RD1, 32'd0);
        check("wr_r2", RD2, 32'd15);

        // Write R3 = 70: old value before the edge, new value after it.
        WE3 = 1'b1; A3 = 4'd3; WD3 = 32'd70; A2 = 4'd3;
        #1;
        check("rdw_old_r3", RD2, 32'd0);
        step();
        exp_regs[3] = 32'd70;
        check("rdw_new_r3", RD2, 32'd70);

        // Write disabled: R3 keeps 70.
        WE3 = 1'b0; A3 = 4'd3; WD3 = 32'd0;
        step();
        A2 = 4'd3;
        #1;
        check("we_off_r3", RD2, 32'd70);

        // R15 mapping and combinational propagation with no clock edge.
        A1 = 4'd15; R15 = 32'd26;
        #1;
        check("r15_26", RD1, 32'd26);
        R15 = 32'd27;
        #1;
        check("r15_27", RD1, 32'd27);
        A2 = 4'd15;
        #1;
        check("r15_port2", RD2, 32'd27);

        // Write to address 15 is ignored; stored registers unchanged.
        WE3 = 1'b1; A3 = 4'd15; WD3 = 32'hDEADBEEF;
        step();
        WE3 = 1'b0;
        R15 = 32'd24; A1 = 4'd15;
        #1;
        check("r15_wr_ignored", RD1, 32'd24);
        sweep_read("after_r15_wr");

        // Reset has priority over a write at the same edge.
        RST = 1'b1; WE3 = 1'b1; A3 = 4'd5; WD3 = 32'h12345678;
        step();
        RST = 1'b0; WE3 = 1'b0;
        for (int i = 0; i < 15; i++) exp_regs[i] = 32'h0;
        A1 = 4'd5; A2 = 4'd2;
        #1;
        check("rst_prio_r5", RD1, 32'h0);
        check("rst_clr_r2", RD2, 32'h0);
        A1 = 4'd3;
        #1;
        check("rst_clr_r3", RD1, 32'h0);

        // Full write sweep, then read every pair including A1 == A2 == 7.
        for (int i = 0; i < 15; i++) begin
            WE3 = 1'b1; A3 = 4'(i); WD3 = 32'hA5A50000 + 32'(i);
            step();
            exp_regs[i] = 32'hA5A50000 + 32'(i);
        end
        WE3 = 1'b0;
        sweep_read("full");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/register_file.md
Name: register_file

Overview:
- 16-entry x 32-bit architectural register file for the ARM-style single-cycle datapath.
- Two asynchronous read ports (A1/RD1, A2/RD2) and one synchronous write port (A3/WD3/WE3).
- Physical storage covers R0–R14 only. Address 15 reads return the externally supplied R15 value (PC+8 from the fetch logic).

Parameters:
- DATA_W, 32, width of each register and of the data ports.
- ADDR_W, 4, address width; the file has 2**ADDR_W entries.
- PC_IDX, 15, index mapped to the R15 input instead of storage.

Ports:
- CLK  input  1  system clock; all state changes on its falling edge.
- RST  input  1  synchronous, active-high reset.
- A1  input  4  read address, port 1.
- A2  input  4  read address, port 2.
- A3  input  4  write address.
- WD3  input  32  write data.
- WE3  input  1  write enable, active-high.
- R15  input  32  PC+8 value, returned for reads of address 15.
- RD1  output  32  read data, port 1.
- RD2  output  32  read data, port 2.

Behaviour:
- Clock and reset:
  - One clock; reset is synchronous and active-high.
  - Sequential updates occur on the falling edge of CLK. This lets a write presented in a cycle be visible before the next rising-edge consumers sample.
  - RST high at a falling edge clears R0–R14 to 0.
  - RST has priority over any write at that edge.
  - Reset asserted mid-operation discards the concurrent write.
- Write:
  - At a falling edge with RST=0 and WE3=1, when A3 != 15: R[A3] <= WD3.
  - WE3=0 leaves all registers unchanged.
  - A3=15 with WE3=1 has no effect, because R15 is not stored (PC writes are handled outside this block).
- Read:
  - Purely combinational; zero latency.
  - RD1 = R15 when A1 = 15, else R[A1]. RD2 is defined the same way from A2.
  - Both ports may address the same register simultaneously and return identical data.
  - R15 input changes propagate to RD1/RD2 combinationally when addressed.
- Read-during-write:
  - No internal bypass.
  - Before the falling edge, a read of A3 returns the old value.
  - After the edge, it returns WD3 combinationally.
- Power-up contents before the first reset are undefined. The bench must reset first.
- No X propagation from unused address bits; all 16 addresses are valid.

Test Plan:
- Reset: RST=1 for one falling edge, then read A1=0..14 and A2=14..0 -> RD1 = RD2 = 0 for all.
- Write then read:
  - Edge 1: WE3=1, A3=2, WD3=15; then A1=1, A2=2 -> RD1=0, RD2=15.
  - Edge 2: WE3=1, A3=3, WD3=70; then A2=3 -> RD2=70.
- Write disable and R15 mapping:
  - WE3=0, A3=3, WD3=0 over an edge -> A2=3 still reads 70.
  - A1=15 with R15=26 -> RD1=26; change R15 to 27 -> RD1=27 with no clock.
- R15 write ignored: WE3=1, A3=15, WD3=0xDEADBEEF, then R15=24 and A1=15 -> RD1=24. All of R0–R14 are unchanged.
- Reset priority: RST=1 and WE3=1, A3=5, WD3=0x12345678 at the same edge -> R5 reads 0. Previously written R2 and R3 read 0.
- Full sweep:
  - Write R[i] = 0xA5A50000 + i for i = 0..14.
  - Read all pairs (A1=i, A2=14-i) -> exact values, including both ports addressing the same register.
